multicycle_control: RTL and testbench

Multicycle sequencer for the MIPS CPU datapath. Walks each instruction through fetch, decode, execute, memory and writeback states, and drives the load strobes for PC/NPC/IR/MAR/MDR, the register file, the ALU and the mux selects. It waits on the RAM's `moc` (memory operation complete) handshake and traps on unknown opcodes or a memory that never answers. It replaces the single-cycle `control` decode in the multicycle datapath variant.

---
 rtl/mcu_pkg.sv | 62 ++++++
 rtl/moc_watchdog.sv | 36 +++
 rtl/multicycle_control.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle MIPS sequencer: state enum, opcodes,
// ALU operation codes and datapath mux selects.
package mcu_pkg;

    typedef enum logic [3:0] {
        FETCH_A  = 4'd0,
        FETCH_W  = 4'd1,
        FETCH_IR = 4'd2,
        DECODE   = 4'd3,
        EXEC_R   = 4'd4,
        EXEC_I   = 4'd5,
        WB       = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        FAULT    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_SLT   = 4'h4;
    localparam logic [3:0] ALU_FUNCT = 4'hF;

    localparam logic [1:0] RF_RT  = 2'd0;
    localparam logic [1:0] RF_RD  = 2'd1;
    localparam logic [1:0] RF_R31 = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_NPC = 2'd2;

    localparam logic [1:0] ASRC_REGB = 2'd0;
    localparam logic [1:0] ASRC_SEXT = 2'd1;
    localparam logic [1:0] ASRC_ZEXT = 2'd2;
    localparam logic [1:0] ASRC_LUI  = 2'd3;

    localparam logic [1:0] PCSEL_NPC = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_JMP = 2'd2;

    function automatic logic is_wait_state(input state_e s);
        return (s == FETCH_W) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/moc_watchdog.sv
// Memory-wait watchdog: counts wait cycles without moc; expired is combinational
// and fires on the cycle the count would reach MOC_TIMEOUT, unless moc is present.
module moc_watchdog #(
    parameter int unsigned MOC_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int unsigned CW = $clog2(MOC_TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expired = tick & ~clear & (count_q == CW'(MOC_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: Moore strobes per state, moc-qualified strobes in waits.
// R/I 6 cycles, lw 7, sw 6, branch/jump 5, +1 per extra wait; stalls on moc, faults on timeout.
module multicycle_control
    import mcu_pkg::*;
#(
    parameter int unsigned MOC_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zFlag,
    input  logic       moc,
    output logic       pcLoad,
    output logic       npcLoad,
    output logic       irLoad,
    output logic       marLoad,
    output logic       mdrLoad,
    output logic       mdrSource,
    output logic       memEnable,
    output logic       rw,
    output logic       regWrite,
    output logic [1:0] rfSource,
    output logic [1:0] wbSource,
    output logic [1:0] aluSource,
    output logic [3:0] aluCode,
    output logic [1:0] pcSelect,
    output logic       fault,
    output logic [3:0] state
);
    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       in_wait;
    logic       wd_expired;

    // funct is decoded by the ALU itself when aluCode is FUNCT.
    logic unused_funct;
    assign unused_funct = ^funct;

    assign in_wait = is_wait_state(state_q);

    moc_watchdog #(.MOC_TIMEOUT(MOC_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (~in_wait),
        .tick    (in_wait & ~moc),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pcLoad    = 1'b0;
        npcLoad   = 1'b0;
        irLoad    = 1'b0;
        marLoad   = 1'b0;
        mdrLoad   = 1'b0;
        mdrSource = 1'b0;
        memEnable = 1'b0;
        rw        = 1'b0;
        regWrite  = 1'b0;
        rfSource  = RF_RT;
        wbSource  = WB_ALU;
        aluSource = ASRC_REGB;
        aluCode   = ALU_ADD;
        pcSelect  = PCSEL_NPC;
        fault     = 1'b0;

        case (state_q)
            FETCH_A: begin
                marLoad = 1'b1;
                state_d = FETCH_W;
            end
            FETCH_W: begin
                memEnable = 1'b1;
                rw        = 1'b1;
                if (moc) begin
                    mdrLoad = 1'b1;
                    state_d = FETCH_IR;
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            FETCH_IR: begin
                irLoad  = 1'b1;
                npcLoad = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                // Later states decode the latched opcode so outputs stay off the IR path.
                op_d = opcode;
                case (opcode)
                    OP_RTYPE:                                 state_d = EXEC_R;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: state_d = EXEC_I;
                    OP_LW, OP_SW:                             state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE:                           state_d = BRANCH;
                    OP_J, OP_JAL:                             state_d = JUMP;
                    default:                                  state_d = FAULT;
                endcase
            end
            EXEC_R: begin
                aluSource = ASRC_REGB;
                aluCode   = ALU_FUNCT;
                state_d   = WB;
            end
            EXEC_I: begin
                case (op_q)
                    OP_ANDI: begin aluSource = ASRC_ZEXT; aluCode = ALU_AND; end
                    OP_ORI:  begin aluSource = ASRC_ZEXT; aluCode = ALU_OR;  end
                    OP_LUI:  begin aluSource = ASRC_LUI;  aluCode = ALU_OR;  end
                    default: begin aluSource = ASRC_SEXT; aluCode = ALU_ADD; end
                endcase
                state_d = WB;
            end
            WB: begin
                regWrite = 1'b1;
                pcLoad   = 1'b1;
                pcSelect = PCSEL_NPC;
                rfSource = (op_q == OP_RTYPE) ? RF_RD : RF_RT;
                wbSource = (op_q == OP_LW) ? WB_MDR : WB_ALU;
                state_d  = FETCH_A;
            end
            MEM_ADDR: begin
                aluSource = ASRC_SEXT;
                aluCode   = ALU_ADD;
                marLoad   = 1'b1;
                if (op_q == OP_SW) begin
                    mdrLoad   = 1'b1;
                    mdrSource = 1'b1;
                    state_d   = MEM_WR;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                memEnable = 1'b1;
                rw        = 1'b1;
                if (moc) begin
                    mdrLoad = 1'b1;
                    state_d = WB;
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            MEM_WR: begin
                memEnable = 1'b1;
                rw        = 1'b0;
                if (moc) begin
                    pcLoad   = 1'b1;
                    pcSelect = PCSEL_NPC;
                    state_d  = FETCH_A;
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            BRANCH: begin
                aluCode  = ALU_SUB;
                pcLoad   = 1'b1;
                pcSelect = (((op_q == OP_BEQ) && zFlag) || ((op_q == OP_BNE) && !zFlag))
                           ? PCSEL_BR : PCSEL_NPC;
                state_d  = FETCH_A;
            end
            JUMP: begin
                pcLoad   = 1'b1;
                pcSelect = PCSEL_JMP;
                if (op_q == OP_JAL) begin
                    regWrite = 1'b1;
                    rfSource = RF_R31;
                    wbSource = WB_NPC;
                end
                state_d = FETCH_A;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        // Reset masks every strobe so an in-flight access is abandoned without side effects.
        if (reset) begin
            pcLoad    = 1'b0;
            npcLoad   = 1'b0;
            irLoad    = 1'b0;
            marLoad   = 1'b0;
            mdrLoad   = 1'b0;
            mdrSource = 1'b0;
            memEnable = 1'b0;
            rw        = 1'b0;
            regWrite  = 1'b0;
            rfSource  = RF_RT;
            wbSource  = WB_ALU;
            aluSource = ASRC_REGB;
            aluCode   = ALU_ADD;
            pcSelect  = PCSEL_NPC;
            fault     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_A;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle vector bench for multicycle_control plus timeout and pcLoad-count sequences.
module tb_multicycle_control;
    import mcu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       zFlag = 1'b0;
    logic       moc = 1'b0;
    logic       pcLoad, npcLoad, irLoad, marLoad, mdrLoad, mdrSource, memEnable, rw, regWrite;
    logic [1:0] rfSource, wbSource, aluSource, pcSelect;
    logic [3:0] aluCode;
    logic       fault;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;
    int pc_cnt = 0;

    multicycle_control #(.MOC_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zFlag(zFlag), .moc(moc),
        .pcLoad(pcLoad), .npcLoad(npcLoad), .irLoad(irLoad), .marLoad(marLoad),
        .mdrLoad(mdrLoad), .mdrSource(mdrSource), .memEnable(memEnable), .rw(rw),
        .regWrite(regWrite), .rfSource(rfSource), .wbSource(wbSource),
        .aluSource(aluSource), .aluCode(aluCode), .pcSelect(pcSelect),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pcLoad === 1'b1) pc_cnt <= pc_cnt + 1;
    end

    // expected word: {state, pc,npc,ir,mar,mdr,mdrSrc,memEn,rw,regWr,fault, rf, wb, asrc, alu, pcsel}
    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        m;
        logic [25:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic r(input logic rst, input logic [5:0] op, input logic z, input logic m,
                     input logic [3:0] st, input logic [9:0] stb, input logic [1:0] rf,
                     input logic [1:0] wb, input logic [1:0] asrc, input logic [3:0] ac,
                     input logic [1:0] ps);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.m = m;
        v.exp = {st, stb, rf, wb, asrc, ac, ps};
        tbl.push_back(v);
    endtask

    task automatic fetch(input logic [5:0] op, input logic z);
        r(0, op, z, 1, FETCH_A,  10'b0001000000, 0, 0, 0, ALU_ADD, 0);
        r(0, op, z, 1, FETCH_W,  10'b0000101100, 0, 0, 0, ALU_ADD, 0);
        r(0, op, z, 1, FETCH_IR, 10'b0110000000, 0, 0, 0, ALU_ADD, 0);
        r(0, op, z, 1, DECODE,   10'b0000000000, 0, 0, 0, ALU_ADD, 0);
    endtask

    function automatic logic [25:0] actual();
        return {state, pcLoad, npcLoad, irLoad, marLoad, mdrLoad, mdrSource, memEnable, rw,
                regWrite, fault, rfSource, wbSource, aluSource, aluCode, pcSelect};
    endfunction

    initial begin
        int n_wait;
        int cycles;

        // reset asserted while already in FETCH_A: marLoad must be masked
        r(1, 6'h00, 0, 1, FETCH_A, 10'b0000000000, 0, 0, 0, ALU_ADD, 0);
        // add, moc immediate: 6 cycles
        fetch(OP_RTYPE, 0);
        r(0, OP_RTYPE, 0, 1, EXEC_R, 10'b0, 0, 0, 0, ALU_FUNCT, 0);
        r(0, OP_RTYPE, 0, 1, WB, 10'b1000000010, RF_RD, WB_ALU, 0, ALU_ADD, 0);
        // lw with three empty wait cycles in MEM_RD: 10 cycles
        fetch(OP_LW, 0);
        r(0, OP_LW, 0, 1, MEM_ADDR, 10'b0001000000, 0, 0, ASRC_SEXT, ALU_ADD, 0);
        for (int i = 0; i < 3; i++)
            r(0, OP_LW, 0, 0, MEM_RD, 10'b0000001100, 0, 0, 0, ALU_ADD, 0);
        r(0, OP_LW, 0, 1, MEM_RD, 10'b0000101100, 0, 0, 0, ALU_ADD, 0);
        r(0, OP_LW, 0, 1, WB, 10'b1000000010, RF_RT, WB_MDR, 0, ALU_ADD, 0);
        // sw with one empty wait in MEM_WR
        fetch(OP_SW, 0);
        r(0, OP_SW, 0, 1, MEM_ADDR, 10'b0001110000, 0, 0, ASRC_SEXT, ALU_ADD, 0);
        r(0, OP_SW, 0, 0, MEM_WR, 10'b0000001000, 0, 0, 0, ALU_ADD, 0);
        r(0, OP_SW, 0, 1, MEM_WR, 10'b1000001000, 0, 0, 0, ALU_ADD, PCSEL_NPC);
        // beq taken, beq not taken, bne taken
        fetch(OP_BEQ, 1);
        r(0, OP_BEQ, 1, 1, BRANCH, 10'b1000000000, 0, 0, 0, ALU_SUB, PCSEL_BR);
        fetch(OP_BEQ, 0);
        r(0, OP_BEQ, 0, 1, BRANCH, 10'b1000000000, 0, 0, 0, ALU_SUB, PCSEL_NPC);
        fetch(OP_BNE, 0);
        r(0, OP_BNE, 0, 1, BRANCH, 10'b1000000000, 0, 0, 0, ALU_SUB, PCSEL_BR);
        // jal and j
        fetch(OP_JAL, 0);
        r(0, OP_JAL, 0, 1, JUMP, 10'b1000000010, RF_R31, WB_NPC, 0, ALU_ADD, PCSEL_JMP);
        fetch(OP_J, 0);
        r(0, OP_J, 0, 1, JUMP, 10'b1000000000, 0, 0, 0, ALU_ADD, PCSEL_JMP);
        // immediate ops
        fetch(OP_ADDI, 0);
        r(0, OP_ADDI, 0, 1, EXEC_I, 10'b0, 0, 0, ASRC_SEXT, ALU_ADD, 0);
        r(0, OP_ADDI, 0, 1, WB, 10'b1000000010, RF_RT, WB_ALU, 0, ALU_ADD, 0);
        fetch(OP_ANDI, 0);
        r(0, OP_ANDI, 0, 1, EXEC_I, 10'b0, 0, 0, ASRC_ZEXT, ALU_AND, 0);
        r(0, OP_ANDI, 0, 1, WB, 10'b1000000010, RF_RT, WB_ALU, 0, ALU_ADD, 0);
        fetch(OP_ORI, 0);
        r(0, OP_ORI, 0, 1, EXEC_I, 10'b0, 0, 0, ASRC_ZEXT, ALU_OR, 0);
        r(0, OP_ORI, 0, 1, WB, 10'b1000000010, RF_RT, WB_ALU, 0, ALU_ADD, 0);
        fetch(OP_LUI, 0);
        r(0, OP_LUI, 0, 1, EXEC_I, 10'b0, 0, 0, ASRC_LUI, ALU_OR, 0);
        r(0, OP_LUI, 0, 1, WB, 10'b1000000010, RF_RT, WB_ALU, 0, ALU_ADD, 0);
        // moc arrives on the cycle the watchdog would expire: moc wins
        r(0, OP_RTYPE, 0, 1, FETCH_A, 10'b0001000000, 0, 0, 0, ALU_ADD, 0);
        for (int i = 0; i < 14; i++)
            r(0, OP_RTYPE, 0, 0, FETCH_W, 10'b0000001100, 0, 0, 0, ALU_ADD, 0);
        r(0, OP_RTYPE, 0, 1, FETCH_W,  10'b0000101100, 0, 0, 0, ALU_ADD, 0);
        r(0, OP_RTYPE, 0, 1, FETCH_IR, 10'b0110000000, 0, 0, 0, ALU_ADD, 0);
        r(0, OP_RTYPE, 0, 1, DECODE,   10'b0, 0, 0, 0, ALU_ADD, 0);
        r(0, OP_RTYPE, 0, 1, EXEC_R,   10'b0, 0, 0, 0, ALU_FUNCT, 0);
        r(0, OP_RTYPE, 0, 1, WB, 10'b1000000010, RF_RD, WB_ALU, 0, ALU_ADD, 0);
        // reset during MEM_WR with moc present: no pcLoad, then FETCH_A
        fetch(OP_SW, 0);
        r(0, OP_SW, 0, 1, MEM_ADDR, 10'b0001110000, 0, 0, ASRC_SEXT, ALU_ADD, 0);
        r(0, OP_SW, 0, 0, MEM_WR, 10'b0000001000, 0, 0, 0, ALU_ADD, 0);
        r(1, OP_SW, 0, 1, MEM_WR, 10'b0, 0, 0, 0, ALU_ADD, 0);
        r(0, OP_SW, 0, 1, FETCH_A, 10'b0001000000, 0, 0, 0, ALU_ADD, 0);
        r(0, OP_SW, 0, 1, FETCH_W, 10'b0000101100, 0, 0, 0, ALU_ADD, 0);
        r(0, 6'h3F, 0, 1, FETCH_IR, 10'b0110000000, 0, 0, 0, ALU_ADD, 0);
        // unknown opcode 0x3F faults from DECODE; fault is sticky, moc ignored
        r(0, 6'h3F, 0, 1, DECODE, 10'b0, 0, 0, 0, ALU_ADD, 0);
        r(0, 6'h3F, 0, 1, FAULT, 10'b0000000001, 0, 0, 0, ALU_ADD, 0);
        r(0, 6'h00, 1, 1, FAULT, 10'b0000000001, 0, 0, 0, ALU_ADD, 0);
        r(0, 6'h00, 0, 0, FAULT, 10'b0000000001, 0, 0, 0, ALU_ADD, 0);
        r(1, 6'h00, 0, 0, FAULT, 10'b0, 0, 0, 0, ALU_ADD, 0);
        r(0, 6'h00, 0, 0, FETCH_A, 10'b0001000000, 0, 0, 0, ALU_ADD, 0);

        reset = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            reset  = tbl[i].rst;
            opcode = tbl[i].op;
            zFlag  = tbl[i].z;
            moc    = tbl[i].m;
            @(negedge clk);
            tests++;
            if (actual() !== tbl[i].exp) begin
                fails++;
                $display("FAIL row %0d: got %h, want %h", i, actual(), tbl[i].exp);
            end
            @(posedge clk); #1;
        end

        tests++;
        if (pc_cnt != 13) begin
            fails++;
            $display("FAIL pcload_count: got %0d, want 13", pc_cnt);
        end

        // watchdog: moc never answers in FETCH_W
        reset = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        moc    = 1'b0;
        opcode = OP_RTYPE;
        n_wait = 0;
        cycles = 0;
        while (cycles < 100) begin
            @(negedge clk);
            if (state == FAULT) break;
            if (state == FETCH_W) n_wait++;
            cycles++;
        end
        tests++;
        if (state != FAULT) begin
            fails++;
            $display("FAIL timeout_reach: state %0d after %0d cycles, want %0d", state, cycles, FAULT);
        end
        tests++;
        if (n_wait != 15) begin
            fails++;
            $display("FAIL timeout_len: got %0d wait cycles, want 15", n_wait);
        end
        moc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (fault !== 1'b1 || pcLoad !== 1'b0 || state != FAULT) begin
                fails++;
                $display("FAIL fault_sticky: fault=%b pcLoad=%b state=%0d, want 1 0 %0d",
                         fault, pcLoad, state, FAULT);
            end
        end
        tests++;
        if (pc_cnt != 13) begin
            fails++;
            $display("FAIL pcload_final: got %0d, want 13", pc_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
